// File: rtl/boreal_frame_assembler.sv
// ---------------------------------------------------------------------------
// boreal_frame_assembler
//
// Collects channel-tagged ADC samples into NUM_CH-wide frames for the cursor
// pipeline. It hunts for channel 0 and then expects channels 1..NUM_CH-1 in
// strict order. Out-of-order tags, illegal tags and intra-frame stalls raise
// one-cycle error pulses and throw away the partial frame. Completed frames
// are presented on a valid/ready output. A frame that completes while the
// output slot is still occupied is dropped and counted.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     one-cycle strobe per incoming sample
//   in_ch        channel tag of the sample
//   in_data      signed raw ADC sample; the OUT_W MSBs are kept
//   frame_valid  assembled frame is available on frame_data
//   frame_ready  consumer takes the frame when frame_valid && frame_ready
//   frame_data   channel k at bits [k*OUT_W +: OUT_W]
//   frame_seq    index of the frame on frame_data (wraps)
//   err_order    pulse: out-of-sequence or illegal tag
//   err_timeout  pulse: too long between samples inside a frame
//   sync_locked  set by a completed frame, cleared by any error
//   drop_cnt     completed frames lost to backpressure (saturating)
// ---------------------------------------------------------------------------
module boreal_frame_assembler #(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 3,
  parameter int ADC_W       = 24,
  parameter int OUT_W       = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [ADC_W-1:0]        in_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [NUM_CH*OUT_W-1:0] frame_data,
  output logic [CNT_W-1:0]        frame_seq,
  output logic                    err_order,
  output logic                    err_timeout,
  output logic                    sync_locked,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int FRAME_W = NUM_CH * OUT_W;
  localparam int TMR_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic {HUNT, FILL} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      exp_q, exp_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [FRAME_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]     next_seq;
  logic                 order_err, tout_err, complete;
  logic                 tag_legal, slot_free;
  logic [OUT_W-1:0]     sample;
  logic                 unused_data;

  // Keep the MSBs only: truncation toward the sign bit, no rounding.
  assign sample      = in_data[ADC_W-1 -: OUT_W];
  assign unused_data = ^in_data;
  assign tag_legal   = (32'(in_ch) < NUM_CH);
  assign slot_free   = !frame_valid || frame_ready;

  // Next-state logic for the hunt/fill machine, the collect buffer and the
  // intra-frame timer. An illegal tag overrides everything and forces a hunt.
  // A sample arriving in FILL always restarts the timer, which is why an
  // order error and a timeout can never occur in the same cycle.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    tmr_d     = tmr_q;
    buf_d     = buf_q;
    order_err = 1'b0;
    tout_err  = 1'b0;
    complete  = 1'b0;
    if (in_valid && !tag_legal) begin
      order_err = 1'b1;
      state_d   = HUNT;
      exp_d     = '0;
      tmr_d     = '0;
      buf_d     = '0;
    end else begin
      case (state_q)
        HUNT: begin
          tmr_d = '0;
          if (in_valid && in_ch == '0) begin
            buf_d              = '0;
            buf_d[0 +: OUT_W]  = sample;
            exp_d              = CH_W'(1);
            state_d            = FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            tmr_d = '0;
            if (in_ch == exp_q) begin
              buf_d[32'(exp_q)*OUT_W +: OUT_W] = sample;
              if (exp_q == LAST_CH) begin
                complete = 1'b1;
                exp_d    = '0;
                state_d  = HUNT;
              end else begin
                exp_d = exp_q + 1'b1;
              end
            end else begin
              // A fresh channel 0 restarts the frame immediately instead of
              // waiting for the next one in HUNT.
              order_err = 1'b1;
              buf_d     = '0;
              if (in_ch == '0) begin
                buf_d[0 +: OUT_W] = sample;
                exp_d             = CH_W'(1);
              end else begin
                exp_d   = '0;
                state_d = HUNT;
              end
            end
          end else if (tmr_q == TMR_LAST) begin
            tout_err = 1'b1;
            tmr_d    = '0;
            buf_d    = '0;
            exp_d    = '0;
            state_d  = HUNT;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          exp_d   = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // State register. The buffer is cleared once its frame has been handed to
  // the output stage so nothing from an old frame can linger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      tmr_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      tmr_q   <= tmr_d;
      buf_q   <= complete ? '0 : buf_d;
    end
  end

  // Output stage. A completed frame loads only if the slot is empty or is
  // being accepted this very cycle; otherwise the held frame stays untouched
  // and the new one is counted as dropped. next_seq only advances on loads so
  // frame_seq numbers the frames the consumer actually sees.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_seq   <= '0;
      next_seq    <= '0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
      sync_locked <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      err_order   <= order_err;
      err_timeout <= tout_err;
      if (order_err || tout_err) begin
        sync_locked <= 1'b0;
      end else if (complete) begin
        sync_locked <= 1'b1;
      end
      if (complete && slot_free) begin
        frame_valid <= 1'b1;
        frame_data  <= buf_d;
        frame_seq   <= next_seq;
        next_seq    <= next_seq + 1'b1;
      end else begin
        if (frame_valid && frame_ready) begin
          frame_valid <= 1'b0;
        end
        if (complete && drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_boreal_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_boreal_frame_assembler
//
// Directed bench for boreal_frame_assembler. The main instance runs with
// NUM_CH=8, CH_W=4 so that tags 8..15 are illegal; a second instance with
// NUM_CH=4, OUT_W=12 repeats the first-frame scenario. Inputs are driven on
// the falling edge and outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_boreal_frame_assembler;

  localparam int TIMEOUT = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [3:0]   in_ch;
  logic [23:0]  in_data;
  logic         frame_valid;
  logic         frame_ready;
  logic [127:0] frame_data;
  logic [15:0]  frame_seq;
  logic         err_order;
  logic         err_timeout;
  logic         sync_locked;
  logic [15:0]  drop_cnt;

  logic         in_valid2;
  logic [1:0]   in_ch2;
  logic [23:0]  in_data2;
  logic         frame_valid2;
  logic [47:0]  frame_data2;
  logic [15:0]  frame_seq2;
  logic         err_order2;
  logic         err_timeout2;
  logic         sync_locked2;
  logic [15:0]  drop_cnt2;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int order_pulses = 0;
  int tout_pulses = 0;

  boreal_frame_assembler #(
    .NUM_CH(8), .CH_W(4), .ADC_W(24), .OUT_W(16), .TIMEOUT_CYC(TIMEOUT), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_seq(frame_seq), .err_order(err_order), .err_timeout(err_timeout),
    .sync_locked(sync_locked), .drop_cnt(drop_cnt)
  );

  boreal_frame_assembler #(
    .NUM_CH(4), .CH_W(2), .ADC_W(24), .OUT_W(12), .TIMEOUT_CYC(TIMEOUT), .CNT_W(16)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ch(in_ch2), .in_data(in_data2),
    .frame_valid(frame_valid2), .frame_ready(1'b1), .frame_data(frame_data2),
    .frame_seq(frame_seq2), .err_order(err_order2), .err_timeout(err_timeout2),
    .sync_locked(sync_locked2), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  // Handshakes are counted on the rising edge, where frame_ready (driven on
  // the falling edge) is stable and frame_valid still holds its pre-edge value.
  always @(posedge clk) begin
    if (rst_n && frame_valid && frame_ready) hs_cnt++;
  end

  always @(negedge clk) begin
    if (err_order) order_pulses++;
    if (err_timeout) tout_pulses++;
  end

  // Reference frame for send_frame(tagv): channel k holds {tagv, k}.
  function automatic logic [127:0] exp_frame(input logic [7:0] tagv);
    logic [127:0] e;
    e = '0;
    for (int k = 0; k < 8; k++) e[k*16 +: 16] = {tagv, 8'(k)};
    return e;
  endfunction

  // All tasks are entered on a falling edge and return on a falling edge.
  task automatic send(input logic [3:0] ch, input logic [23:0] d);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tagv);
    for (int k = 0; k < 8; k++) send(4'(k), {tagv, 8'(k), 8'hA5});
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({frame_valid, err_order, err_timeout, sync_locked} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {frame_valid, err_order, err_timeout, sync_locked});
    end
    checks++;
    if ({frame_data, frame_seq, drop_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got data=%h seq=%0d drop=%0d expected all 0", frame_data, frame_seq, drop_cnt);
    end
  endtask

  task automatic test_first_frame();
    logic [127:0] e;
    e = '0;
    e[31:16] = 16'd10000;
    frame_ready = 1'b1;
    send(4'd0, 24'h0);
    send(4'd1, 24'h271000);
    for (int k = 2; k < 7; k++) send(4'(k), 24'h0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_early_valid: got %b expected 0", frame_valid);
    end
    send(4'd7, 24'h0);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== e) begin
      errors++;
      $display("[TB] FAIL first_frame: got valid=%b data=%h expected valid=1 data=%h", frame_valid, frame_data, e);
    end
    checks++;
    if (frame_seq !== 16'd0 || sync_locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_seq_lock: got seq=%0d lock=%b expected seq=0 lock=1", frame_seq, sync_locked);
    end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_accept: got valid=%b expected 0", frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    int hs0, op0, tp0;
    apply_reset();
    frame_ready = 1'b1;
    hs0 = hs_cnt;
    op0 = order_pulses;
    tp0 = tout_pulses;
    for (int f = 0; f < 100; f++) begin
      send_frame(8'(f));
      checks++;
      if (frame_valid !== 1'b1 || frame_seq !== 16'(f) || frame_data !== exp_frame(8'(f))) begin
        errors++;
        $display("[TB] FAIL b2b_frame%0d: got valid=%b seq=%0d data=%h expected valid=1 seq=%0d data=%h",
                 f, frame_valid, frame_seq, frame_data, f, exp_frame(8'(f)));
      end
    end
    @(negedge clk);
    checks++;
    if (hs_cnt - hs0 !== 100 || drop_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL b2b_handshakes: got hs=%0d drop=%0d expected hs=100 drop=0", hs_cnt - hs0, drop_cnt);
    end
    checks++;
    if (order_pulses != op0 || tout_pulses != tp0) begin
      errors++;
      $display("[TB] FAIL b2b_errors: got order=%0d timeout=%0d expected 0 0", order_pulses - op0, tout_pulses - tp0);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    frame_ready = 1'b0;
    send_frame(8'h60);
    checks++;
    if (frame_valid !== 1'b1 || frame_seq !== 16'd0) begin
      errors++;
      $display("[TB] FAIL bp_first: got valid=%b seq=%0d expected valid=1 seq=0", frame_valid, frame_seq);
    end
    send_frame(8'h61);
    send_frame(8'h62);
    checks++;
    if (frame_data !== exp_frame(8'h60) || frame_seq !== 16'd0 || frame_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_hold: got valid=%b seq=%0d data=%h expected valid=1 seq=0 data=%h",
               frame_valid, frame_seq, frame_data, exp_frame(8'h60));
    end
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL bp_drop: got %0d expected 2", drop_cnt);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b expected 0", frame_valid);
    end
    send_frame(8'h63);
    checks++;
    if (frame_seq !== 16'd1 || frame_data !== exp_frame(8'h63)) begin
      errors++;
      $display("[TB] FAIL bp_next: got seq=%0d data=%h expected seq=1 data=%h", frame_seq, frame_data, exp_frame(8'h63));
    end
  endtask

  task automatic test_order_error();
    apply_reset();
    frame_ready = 1'b1;
    send_frame(8'h40);
    @(negedge clk);
    send(4'd0, 24'h111100);
    send(4'd1, 24'h222200);
    send(4'd3, 24'h333300);
    checks++;
    if (err_order !== 1'b1 || sync_locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL order_pulse: got err=%b lock=%b expected err=1 lock=0", err_order, sync_locked);
    end
    send(4'd2, 24'h444400);
    checks++;
    if (err_order !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL order_hunt: got err=%b valid=%b expected 0 0", err_order, frame_valid);
    end
    send_frame(8'h41);
    checks++;
    if (frame_valid !== 1'b1 || frame_seq !== 16'd1 || frame_data !== exp_frame(8'h41)) begin
      errors++;
      $display("[TB] FAIL order_recover: got valid=%b seq=%0d data=%h expected valid=1 seq=1 data=%h",
               frame_valid, frame_seq, frame_data, exp_frame(8'h41));
    end
    // A second channel 0 mid-frame restarts the frame with that sample.
    send(4'd0, 24'h505000);
    send(4'd1, 24'h515100);
    send(4'd0, {8'h42, 8'd0, 8'hA5});
    checks++;
    if (err_order !== 1'b1) begin
      errors++;
      $display("[TB] FAIL order_restart_pulse: got %b expected 1", err_order);
    end
    for (int k = 1; k < 8; k++) send(4'(k), {8'h42, 8'(k), 8'hA5});
    checks++;
    if (frame_valid !== 1'b1 || frame_seq !== 16'd2 || frame_data !== exp_frame(8'h42)) begin
      errors++;
      $display("[TB] FAIL order_restart_frame: got valid=%b seq=%0d data=%h expected valid=1 seq=2 data=%h",
               frame_valid, frame_seq, frame_data, exp_frame(8'h42));
    end
  endtask

  task automatic test_timeout();
    int first_k, pulses;
    apply_reset();
    frame_ready = 1'b1;
    send_frame(8'h30);
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(4'(k), 24'h777700);
    first_k = -1;
    pulses  = 0;
    for (int k = 1; k <= TIMEOUT + 3; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    checks++;
    if (pulses != 1 || first_k != TIMEOUT) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got pulses=%0d at=%0d expected pulses=1 at=%0d", pulses, first_k, TIMEOUT);
    end
    checks++;
    if (sync_locked !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: got lock=%b valid=%b expected 0 0", sync_locked, frame_valid);
    end
    for (int k = 4; k < 8; k++) send(4'(k), 24'h888800);
    checks++;
    if (frame_valid !== 1'b0 || err_order !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_discard: got valid=%b err=%b expected 0 0", frame_valid, err_order);
    end
  endtask

  task automatic test_illegal_tag();
    apply_reset();
    frame_ready = 1'b1;
    send_frame(8'h20);
    @(negedge clk);
    send(4'd0, 24'h0);
    send(4'd1, 24'h0);
    send(4'd9, 24'h0);
    checks++;
    if (err_order !== 1'b1 || sync_locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_pulse: got err=%b lock=%b expected err=1 lock=0", err_order, sync_locked);
    end
    for (int k = 2; k < 8; k++) send(4'(k), 24'h0);
    checks++;
    if (frame_valid !== 1'b0 || err_order !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_hunt: got valid=%b err=%b expected 0 0", frame_valid, err_order);
    end
    send(4'd12, 24'h0);
    checks++;
    if (err_order !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_in_hunt: got %b expected 1", err_order);
    end
  endtask

  task automatic test_reset_midframe();
    frame_ready = 1'b0;
    send_frame(8'h70);
    send(4'd0, 24'h0);
    send(4'd1, 24'h0);
    send(4'd2, 24'h0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_valid, err_order, err_timeout, sync_locked} !== 4'b0000 || {frame_data, frame_seq, drop_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset: got valid=%b lock=%b seq=%0d drop=%0d data=%h expected all 0",
               frame_valid, sync_locked, frame_seq, drop_cnt, frame_data);
    end
    rst_n = 1'b1;
    frame_ready = 1'b1;
    for (int k = 3; k < 8; k++) send(4'(k), 24'h0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_partial: got valid=%b expected 0", frame_valid);
    end
    send_frame(8'h71);
    checks++;
    if (frame_seq !== 16'd0 || frame_data !== exp_frame(8'h71)) begin
      errors++;
      $display("[TB] FAIL midreset_next: got seq=%0d data=%h expected seq=0 data=%h", frame_seq, frame_data, exp_frame(8'h71));
    end
  endtask

  task automatic test_small_build();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid2 = 1'b1;
      in_ch2    = 2'(k);
      in_data2  = (k == 1) ? 24'h271000 : 24'h0;
      @(negedge clk);
      in_valid2 = 1'b0;
    end
    checks++;
    if (frame_valid2 !== 1'b1 || frame_data2 !== 48'h000000271000) begin
      errors++;
      $display("[TB] FAIL small_frame: got valid=%b data=%h expected valid=1 data=000000271000", frame_valid2, frame_data2);
    end
    checks++;
    if (frame_seq2 !== 16'd0 || sync_locked2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL small_seq_lock: got seq=%0d lock=%b expected seq=0 lock=1", frame_seq2, sync_locked2);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_ch       = '0;
    in_data     = '0;
    frame_ready = 1'b0;
    in_valid2   = 1'b0;
    in_ch2      = '0;
    in_data2    = '0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_backpressure();
    test_order_error();
    test_timeout();
    test_illegal_tag();
    test_reset_midframe();
    test_small_build();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
